vga_timing_generator: RTL

- Upstream stage of display_syncronization: produces the raw VGA scan counters h_count/v_count, the new_line strobe, hsync/vsync and video_on.
- Derives the pixel rate from the system clock via an internal clock-enable divider.
- Default timing is 640x480@60 (800x525 total); every timing value is a parameter.

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_timing_generator_if.sv | 34 +++
 rtl/pixel_tick_divider.sv | 39 +++
 rtl/vga_timing_generator.sv | 136 +++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared VGA timing constants (640x480@60 defaults), derived
//               sync window bounds, coordinate width and a window helper.
//               Used by vga_timing_generator and display_syncronization.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int COORD_W = 10;
    localparam int FRAME_W = 8;

    // Default 640x480@60 timing, 25 MHz pixel clock
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Inclusive sync windows for the default timing
    localparam int H_SYNC_START = H_VIS + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VIS + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // True when pos lies inside the inclusive range [first, last]
    function automatic logic in_window(input logic [COORD_W-1:0] pos,
                                       input logic [COORD_W-1:0] first,
                                       input logic [COORD_W-1:0] last);
        return (pos >= first) && (pos <= last);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_generator_if
// Description : Raw scan-timing bundle produced by vga_timing_generator.
//               master : driven by the timing generator
//               slave  : consumed by downstream display stages
// Signals     : pix_tick, h_count, v_count, new_line, new_frame,
//               hsync, vsync, video_on, frame_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_generator_if;
    import vga_timing_pkg::*;

    logic               pix_tick;
    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] v_count;
    logic               new_line;
    logic               new_frame;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        output pix_tick, h_count, v_count, new_line, new_frame,
               hsync, vsync, video_on, frame_cnt
    );

    modport slave (
        input  pix_tick, h_count, v_count, new_line, new_frame,
               hsync, vsync, video_on, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pixel_tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : pixel_tick_divider
// Description : Clock-enable divider. Emits a one-clk pix_tick every CLK_DIV
//               system clocks while en is high; freezes while en is low.
// Ports       : clk      - system clock
//               rst      - asynchronous active-low reset
//               en       - run enable
//               pix_tick - one-clk pulse per pixel period
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_tick_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pix_tick
);

    // A 1-bit counter is kept for CLK_DIV=1; it simply never leaves 0,
    // so pix_tick degenerates to en without a separate code path.
    localparam int              c_dw   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_dw-1:0] c_last = c_dw'(CLK_DIV - 1);

    logic [c_dw-1:0] r_div_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
        end else if (en) begin
            r_div_cnt <= (r_div_cnt == c_last) ? '0 : r_div_cnt + 1'b1;
        end
    end

    assign pix_tick = en && (r_div_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_generator
// Description : VGA scan timing: pixel-rate divider, horizontal/vertical
//               counters, line/frame strobes, registered hsync/vsync/video_on
//               and a wrapping frame counter. All timing is parameterised.
// Ports       : clk - system clock
//               rst - asynchronous active-low reset
//               en  - run enable (low freezes everything, strobes forced 0)
//               tim - vga_timing_generator_if master (timing outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_generator #(
    parameter int   CLK_DIV = 2,
    parameter int   H_VIS   = vga_timing_pkg::H_VIS,
    parameter int   H_FP    = vga_timing_pkg::H_FP,
    parameter int   H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int   H_BP    = vga_timing_pkg::H_BP,
    parameter int   V_VIS   = vga_timing_pkg::V_VIS,
    parameter int   V_FP    = vga_timing_pkg::V_FP,
    parameter int   V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int   V_BP    = vga_timing_pkg::V_BP,
    parameter logic HS_POL  = 1'b0,
    parameter logic VS_POL  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    vga_timing_generator_if.master tim
);
    import vga_timing_pkg::*;

    localparam int c_h_total = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] c_h_last   = COORD_W'(c_h_total - 1);
    localparam logic [COORD_W-1:0] c_v_last   = COORD_W'(c_v_total - 1);
    localparam logic [COORD_W-1:0] c_h_vis    = COORD_W'(H_VIS);
    localparam logic [COORD_W-1:0] c_v_vis    = COORD_W'(V_VIS);
    localparam logic [COORD_W-1:0] c_hs_first = COORD_W'(H_VIS + H_FP);
    localparam logic [COORD_W-1:0] c_hs_last  = COORD_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] c_vs_first = COORD_W'(V_VIS + V_FP);
    localparam logic [COORD_W-1:0] c_vs_last  = COORD_W'(V_VIS + V_FP + V_SYNC - 1);

    // Elaboration-time parameter sanity
    if (CLK_DIV < 1) begin : g_chk_div
        $error("vga_timing_generator: CLK_DIV must be >= 1");
    end
    if (c_h_total > 1024) begin : g_chk_h
        $error("vga_timing_generator: H_TOTAL exceeds 1024");
    end
    if (c_v_total > 1024) begin : g_chk_v
        $error("vga_timing_generator: V_TOTAL exceeds 1024");
    end

    logic               w_tick;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_new_line;
    logic               w_new_frame;
    logic [COORD_W-1:0] w_h_nxt;
    logic [COORD_W-1:0] w_v_nxt;
    logic [FRAME_W-1:0] w_frame_nxt;

    logic [COORD_W-1:0] r_h_count;
    logic [COORD_W-1:0] r_v_count;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;

    pixel_tick_divider #(
        .CLK_DIV  (CLK_DIV)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pix_tick (w_tick)
    );

    // Next-state counters; without a tick they hold, which also covers en=0
    always_comb begin
        w_h_last    = (r_h_count == c_h_last);
        w_v_last    = (r_v_count == c_v_last);
        w_new_line  = w_tick && w_h_last;
        w_new_frame = w_new_line && w_v_last;
        w_h_nxt     = r_h_count;
        w_v_nxt     = r_v_count;
        w_frame_nxt = r_frame_cnt;
        if (w_tick) begin
            if (w_h_last) begin
                w_h_nxt = '0;
                if (w_v_last) begin
                    w_v_nxt     = '0;
                    w_frame_nxt = r_frame_cnt + 1'b1;
                end else begin
                    w_v_nxt = r_v_count + 1'b1;
                end
            end else begin
                w_h_nxt = r_h_count + 1'b1;
            end
        end
    end

    // Sync/blank flags are decoded from the next-state counters so that the
    // registered flags line up with the counters on the same clk edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_count   <= '0;
            r_v_count   <= '0;
            r_frame_cnt <= '0;
            r_hsync     <= ~HS_POL;
            r_vsync     <= ~VS_POL;
            r_video_on  <= 1'b1;
        end else begin
            r_h_count   <= w_h_nxt;
            r_v_count   <= w_v_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_hsync     <= in_window(w_h_nxt, c_hs_first, c_hs_last) ? HS_POL : ~HS_POL;
            r_vsync     <= in_window(w_v_nxt, c_vs_first, c_vs_last) ? VS_POL : ~VS_POL;
            r_video_on  <= (w_h_nxt < c_h_vis) && (w_v_nxt < c_v_vis);
        end
    end

    assign tim.pix_tick  = w_tick;
    assign tim.h_count   = r_h_count;
    assign tim.v_count   = r_v_count;
    assign tim.new_line  = w_new_line;
    assign tim.new_frame = w_new_frame;
    assign tim.hsync     = r_hsync;
    assign tim.vsync     = r_vsync;
    assign tim.video_on  = r_video_on;
    assign tim.frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
